fcmp_arb: RTL and testbench
===========================

FCMP_ARB -- requirements
Module: fcmp_arb

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  asynchronous reset, active low.
REQ-002 The block SHALL have these request ports, one set per requester n in {0,1}:
- reqn_valid  in  1  request present.
- reqn_ready  out  1  request accepted this cycle when high together with reqn_valid.
- reqn_op  in  2  operation: 00 FEQ, 01 FLT, 10 FLE, 11 reserved.
- reqn_x1  in  32  IEEE-754 single-precision operand 1.
- reqn_x2  in  32  IEEE-754 single-precision operand 2.
REQ-003 The block SHALL have these result ports:
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result this cycle.
- out_id  out  1  requester that issued the result.
- out_res  out  1  comparison result.
- out_nv  out  1  invalid-operation flag.

Function
REQ-004 The block SHALL share one combinational comparator between the two requesters and grant at most one request per cycle.
- Grant rule: a request is accepted when reqn_valid && reqn_ready.
- reqn_ready is high only for the granted requester, and only when the output register is empty or drained this cycle.
- Drained means out_valid && out_ready.
REQ-005 Arbitration SHALL be round-robin with a 1-bit priority pointer.
- The pointer names the preferred requester.
- The pointer updates only on an accepted request, to the requester that was not granted.
- If only one requester is valid, that requester is granted regardless of the pointer.
REQ-006 Latency SHALL be one cycle: out_valid, out_id, out_res and out_nv are registered at the edge where the request is accepted.
REQ-007 Back-to-back throughput SHALL be one result per cycle: when out_valid && out_ready, a new accept in the same cycle reloads the output register with no bubble.
REQ-008 Stall: while out_valid && !out_ready, both readies SHALL be low and out_valid, out_id, out_res and out_nv SHALL hold stable.
REQ-009 An operand is zero when exp==0 and mantissa==0; +0 and -0 SHALL compare equal.
REQ-010 Denormals SHALL be compared by value, with no flush to zero.
REQ-011 Comparison results for non-NaN operands SHALL be:
- FEQ: 1 when the bit patterns are equal or both operands are zero.
- FLT: strict sign-magnitude ordering; a negative operand is below a positive one; zeros compare equal.
- FLE: FLT or FEQ.
REQ-012 Op 11 SHALL be accepted and produce out_res=0, out_nv=1.
REQ-013 A new request SHALL never overwrite an unconsumed result.

Reset
REQ-014 While rstn is low, the block SHALL asynchronously force these values:
- out_valid=0, out_id=0, out_res=0, out_nv=0.
- Priority pointer=0.
- req0_ready=0, req1_ready=0.
REQ-015 Reset mid-operation SHALL discard any held result without delivering it.
REQ-016 After rstn deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-017 Macro FCMP_NAN_CHECK_EN SHALL select NaN handling (NaN: exp==255, mantissa!=0).
REQ-018 With FCMP_NAN_CHECK_EN defined, NaN handling SHALL be:
- Any NaN operand forces out_res=0 for all ops.
- out_nv=1 for FLT/FLE with any NaN.
- out_nv=1 for FEQ only when a NaN is signalling (mantissa bit 22 = 0).
REQ-019 Without FCMP_NAN_CHECK_EN, NaN handling SHALL be:
- NaN is treated as an ordinary encoding under REQ-011.
- out_nv=1 only for op 11.
- No NaN detection logic is present.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
1. Req0 only, op FEQ, x1=32'h80000000, x2=32'h00000000 -> next cycle out_valid=1, out_id=0, out_res=1, out_nv=0.
2. Both valid every cycle, out_ready=1, pointer=0 after reset -> grants alternate 0,1,0,1 and out_id alternates 0,1,0,1 with no idle cycle.
3. Result held, out_ready=0 for 3 cycles with both requests valid -> both readies stay 0, out_* stable; on the cycle out_ready=1, the next grant loads.
4. Op FLT, x1=32'hBF800000 (-1.0), x2=32'h00000001 (min denormal) -> out_res=1; op FLE with the operands swapped -> out_res=0.
5. With FCMP_NAN_CHECK_EN: op FEQ, x1=32'h7FC00000, x2=32'h7FC00000 -> out_res=0, out_nv=0; op FLT, x1=32'h7F800001, x2=0 -> out_res=0, out_nv=1. Without the macro: the same FEQ gives out_res=1.
6. rstn pulsed low while out_valid=1 and out_ready=0 -> out_valid drops immediately, and the held result never appears after release.

Source files
------------

// File: rtl/fcmp_arb_if.sv
// -----------------------------------------------------------------------------
// fcmp_arb_if -- bundle of request/result handshake signals for fcmp_arb.
//
// Signals (per requester n in {0,1}):
//   reqn_valid  request present
//   reqn_ready  request accepted this cycle when high with reqn_valid
//   reqn_op     00 FEQ, 01 FLT, 10 FLE, 11 reserved
//   reqn_x1/x2  IEEE-754 single-precision operands
// Result side:
//   out_valid   result held in the output register
//   out_ready   consumer takes the result this cycle
//   out_id      requester that issued the result
//   out_res     comparison result
//   out_nv      invalid-operation flag
//
// Modports: slave  = comparator/arbiter side (fcmp_arb)
//           master = requesters + result consumer side
// -----------------------------------------------------------------------------
interface fcmp_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_x1;
  logic [31:0] req0_x2;

  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_x1;
  logic [31:0] req1_x2;

  logic        out_valid;
  logic        out_ready;
  logic        out_id;
  logic        out_res;
  logic        out_nv;

  modport slave (
    input  req0_valid, req0_op, req0_x1, req0_x2,
    input  req1_valid, req1_op, req1_x1, req1_x2,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_id, out_res, out_nv
  );

  modport master (
    output req0_valid, req0_op, req0_x1, req0_x2,
    output req1_valid, req1_op, req1_x1, req1_x2,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_id, out_res, out_nv
  );
endinterface

// File: rtl/fcmp_arb.sv
// -----------------------------------------------------------------------------
// fcmp_arb -- two-requester round-robin arbiter in front of one shared
// single-precision compare unit (FEQ/FLT/FLE) with a one-entry output register.
//
// Ports:
//   clk   sole clock, rising edge
//   rstn  asynchronous reset, active low
//   bus   fcmp_arb_if.slave -- request handshakes and registered result
//
// Behaviour: at most one accept per cycle; a request is accepted when the
// output register is empty or being drained this cycle, so results stream at
// one per cycle with one cycle of latency and are never overwritten.
//
// Configuration macro: FCMP_NAN_CHECK_EN
//   defined   -> NaN operands force res=0; nv set for FLT/FLE with any NaN
//                and for FEQ with a signalling NaN.
//   undefined -> NaN is compared as an ordinary encoding; no NaN logic.
// -----------------------------------------------------------------------------
module fcmp_arb (
  input  logic       clk,
  input  logic       rstn,
  fcmp_arb_if.slave  bus
);

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic out_valid_q, out_valid_d;
  logic out_id_q,    out_id_d;
  logic out_res_q,   out_res_d;
  logic out_nv_q,    out_nv_d;
  logic ptr_q,       ptr_d;

  // ---------------------------------------------------------------------------
  // Arbitration: the pointer only matters when both requesters are valid.
  // ---------------------------------------------------------------------------
  logic any_valid;
  logic grant;
  logic out_free;
  logic accept;

  assign any_valid = bus.req0_valid || bus.req1_valid;
  assign grant     = (bus.req0_valid && bus.req1_valid) ? ptr_q : !bus.req0_valid;
  assign out_free  = !out_valid_q || bus.out_ready;
  // rstn gates the readies so they read low while reset is asserted.
  assign accept    = rstn && out_free && any_valid;

  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept &&  grant;

  // ---------------------------------------------------------------------------
  // Shared comparator on the granted request.
  // ---------------------------------------------------------------------------
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  assign op = grant ? bus.req1_op : bus.req0_op;
  assign a  = grant ? bus.req1_x1 : bus.req0_x1;
  assign b  = grant ? bus.req1_x2 : bus.req0_x2;

  logic both_zero;
  logic is_eq;
  logic is_lt;
  logic cmp_res;
  logic cmp_nv;

  // +0 and -0 differ only in the sign bit, so zero detection ignores it.
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
  assign is_eq     = (a == b) || both_zero;

  // Sign-magnitude ordering: exponent and mantissa concatenated compare as an
  // unsigned magnitude, which orders denormals correctly without flushing.
  always_comb begin
    unique case ({a[31], b[31]})
      2'b00:   is_lt = a[30:0] < b[30:0];
      2'b11:   is_lt = a[30:0] > b[30:0];
      2'b10:   is_lt = !both_zero;
      default: is_lt = 1'b0;
    endcase
  end

`ifdef FCMP_NAN_CHECK_EN
  logic a_nan, b_nan, any_snan;
  assign a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  // Quiet NaNs have mantissa bit 22 set; a clear bit 22 marks signalling.
  assign any_snan = (a_nan && !a[22]) || (b_nan && !b[22]);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cmp_res = 1'b0;
    cmp_nv  = 1'b0;
    unique case (op)
      OP_FEQ:  cmp_res = is_eq;
      OP_FLT:  cmp_res = is_lt;
      OP_FLE:  cmp_res = is_lt || is_eq;
      default: cmp_nv  = 1'b1;
    endcase
`ifdef FCMP_NAN_CHECK_EN
    if (a_nan || b_nan) begin
      cmp_res = 1'b0;
      unique case (op)
        OP_FEQ:  cmp_nv = any_snan;
        default: cmp_nv = 1'b1;
      endcase
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output register and priority pointer.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_res_d   = out_res_q;
    out_nv_d    = out_nv_q;
    ptr_d       = ptr_q;
    if (accept) begin
      // Covers the drain-and-reload case too: no bubble between results.
      out_valid_d = 1'b1;
      out_id_d    = grant;
      out_res_d   = cmp_res;
      out_nv_d    = cmp_nv;
      ptr_d       = !grant;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_res_q   <= 1'b0;
      out_nv_q    <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples its pre-edge inputs regardless of statement order.
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_res_q   <= out_res_d;
      out_nv_q    <= out_nv_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_nv    = out_nv_q;

endmodule

// File: tb/tb_fcmp_arb.sv
// -----------------------------------------------------------------------------
// tb_fcmp_arb -- scoreboard bench for fcmp_arb.
// A driver applies one cycle of stimulus at a time, steps a transaction-level
// model (occupancy + round-robin pointer + value-based compare) and pushes the
// expected result; a monitor pops and compares whenever a result is consumed.
// Build with +define+FCMP_NAN_CHECK_EN to exercise the NaN-aware variant.
// -----------------------------------------------------------------------------
module tb_fcmp_arb;

  typedef struct packed {
    logic id;
    logic res;
    logic nv;
  } exp_t;

  logic clk;
  logic rstn;
  fcmp_arb_if bus ();

  fcmp_arb dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic m_occ = 1'b0;
  logic m_ptr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --- reference compare: map each float onto a signed integer line --------
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic eq, lt;
    if (op == 2'b11) return 2'b01;
`ifdef FCMP_NAN_CHECK_EN
    if (is_nan(a) || is_nan(b)) begin
      if (op != 2'b00) return 2'b01;
      return {1'b0, (is_nan(a) && !a[22]) || (is_nan(b) && !b[22])};
    end
`endif
    eq = fkey(a) == fkey(b);
    lt = fkey(a) <  fkey(b);
    case (op)
      2'b00:   return {eq, 1'b0};
      2'b01:   return {lt, 1'b0};
      default: return {lt || eq, 1'b0};
    endcase
  endfunction

  // --- stimulus helpers -----------------------------------------------------
  task automatic set_req(input int n, input logic v, input logic [1:0] op,
                         input logic [31:0] x1, input logic [31:0] x2);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_x1 = x1; bus.req0_x2 = x2;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_x1 = x1; bus.req1_x2 = x2;
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already applied; checks
  // the pre-edge state against the model, advances the model, and returns
  // 1 time unit after the next rising edge.
  task automatic cycle();
    logic free, g, acc;
    exp_t e;
    logic [1:0] rn;
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_occ));
    if (m_occ) begin
      if (sb.size() == 0) check("held_result_missing", 32'd1, 32'd0);
      else begin
        check("held_id",  32'(bus.out_id),  32'(sb[0].id));
        check("held_res", 32'(bus.out_res), 32'(sb[0].res));
        check("held_nv",  32'(bus.out_nv),  32'(sb[0].nv));
      end
    end
    free = !m_occ || bus.out_ready;
    acc  = free && (bus.req0_valid || bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) g = m_ptr;
    else g = bus.req1_valid;
    check("req0_ready", 32'(bus.req0_ready), 32'(acc && !g));
    check("req1_ready", 32'(bus.req1_ready), 32'(acc && g));
    if (acc) begin
      rn = g ? ref_cmp(bus.req1_op, bus.req1_x1, bus.req1_x2)
             : ref_cmp(bus.req0_op, bus.req0_x1, bus.req0_x2);
      e.id = g; e.res = rn[1]; e.nv = rn[0];
      sb.push_back(e);
      m_occ = 1'b1;
      m_ptr = !g;
    end else if (m_occ && bus.out_ready) begin
      m_occ = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  // Entered/left 1 time unit after a rising edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_id",    32'(bus.out_id),    32'd0);
    check("rst_out_res",   32'(bus.out_res),   32'd0);
    check("rst_out_nv",    32'(bus.out_nv),    32'd0);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    sb.delete();
    m_occ = 1'b0;
    m_ptr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] rand_fp(input logic [31:0] other);
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 7))
      0:       return $urandom;
      1:       return {s, 31'd0};
      2:       return {s, 8'd0, 23'($urandom_range(1, 15))};
      3:       return {s, 8'hFF, 23'd0};
      4:       return {s, 8'hFF, 1'b1, 22'($urandom)};
      5:       return {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
      6:       return {s, 8'd127, 23'($urandom_range(0, 3))};
      default: return other;
    endcase
  endfunction

  // --- monitor: pops when the consumer takes a result -----------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("mon_id",  32'(bus.out_id),  32'(e.id));
          check("mon_res", 32'(bus.out_res), 32'(e.res));
          check("mon_nv",  32'(bus.out_nv),  32'(e.nv));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --- main sequence ---------------------------------------------------------
  initial begin
    logic [31:0] x1, x2;
    rstn = 1'b0;
    bus.out_ready = 1'b1;
    set_req(0, 1'b1, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b1, 2'b00, 32'd0, 32'd0);
    @(posedge clk); #1;
    do_reset();

    // 1: -0 FEQ +0 from requester 0 alone
    idle();
    set_req(0, 1'b1, 2'b00, 32'h8000_0000, 32'h0000_0000);
    cycle();
    check("s1_valid", 32'(bus.out_valid), 32'd1);
    check("s1_id",    32'(bus.out_id),    32'd0);
    check("s1_res",   32'(bus.out_res),   32'd1);
    check("s1_nv",    32'(bus.out_nv),    32'd0);
    idle();
    cycle();

    // 2: both valid every cycle from a fresh pointer -> 0,1,0,1
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 2'b01, 32'h3F80_0000, 32'h4000_0000);
      set_req(1, 1'b1, 2'b10, 32'h4000_0000, 32'h3F80_0000);
      cycle();
      check("s2_valid", 32'(bus.out_valid), 32'd1);
      check("s2_id",    32'(bus.out_id),    32'(i % 2));
    end

    // 3: stall with both requests valid, then release
    bus.out_ready = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    bus.out_ready = 1'b1;
    cycle();
    idle();
    cycle();

    // 4: -1.0 vs smallest positive denormal
    set_req(0, 1'b1, 2'b01, 32'hBF80_0000, 32'h0000_0001);
    cycle();
    check("s4_flt", 32'(bus.out_res), 32'd1);
    idle();
    set_req(1, 1'b1, 2'b10, 32'h0000_0001, 32'hBF80_0000);
    cycle();
    check("s4_fle", 32'(bus.out_res), 32'd0);

    // 5: NaN handling, both builds
    idle();
    set_req(0, 1'b1, 2'b00, 32'h7FC0_0000, 32'h7FC0_0000);
    cycle();
`ifdef FCMP_NAN_CHECK_EN
    check("s5_feq_qnan_res", 32'(bus.out_res), 32'd0);
`else
    check("s5_feq_qnan_res", 32'(bus.out_res), 32'd1);
`endif
    check("s5_feq_qnan_nv", 32'(bus.out_nv), 32'd0);
    idle();
    set_req(0, 1'b1, 2'b01, 32'h7F80_0001, 32'h0000_0000);
    cycle();
`ifdef FCMP_NAN_CHECK_EN
    check("s5_flt_snan_res", 32'(bus.out_res), 32'd0);
    check("s5_flt_snan_nv",  32'(bus.out_nv),  32'd1);
`else
    check("s5_flt_snan_nv",  32'(bus.out_nv),  32'd0);
`endif
    idle();
    set_req(1, 1'b1, 2'b11, 32'h3F80_0000, 32'h3F80_0000);
    cycle();
    check("op11_res", 32'(bus.out_res), 32'd0);
    check("op11_nv",  32'(bus.out_nv),  32'd1);

    // 6: reset while a result is held and stalled
    idle();
    bus.out_ready = 1'b0;
    set_req(0, 1'b1, 2'b00, 32'h1234_5678, 32'h1234_5678);
    cycle();
    check("s6_held", 32'(bus.out_valid), 32'd1);
    idle();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        x1 = rand_fp($urandom);
        x2 = rand_fp(x1);
        set_req(n, 1'($urandom_range(0, 3) != 0), 2'($urandom), x1, x2);
      end
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    // drain
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
